// File: rtl/trigger_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trigger_capture_pkg
// Description : Shared types for the pre/post-trigger capture buffer:
//               trigger-mode encoding and capture FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package trigger_capture_pkg;

  // Trigger qualifier selection, sampled at arm.
  typedef enum logic [1:0] {
    MODE_LEVEL = 2'd0,  // trig high
    MODE_EDGE  = 2'd1,  // trig rising edge
    MODE_MATCH = 2'd2,  // masked data compare
    MODE_IMM   = 2'd3   // fire on the first eligible cycle
  } trig_mode_t;

  // Capture controller states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    READ = 3'd4
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/trigger_capture_buf_ram.sv
`default_nettype none
// ============================================================================
// Module      : capture_ram
// Description : DEPTH x DATA_W register-array sample store. One synchronous
//               write port, one asynchronous (combinational) read port.
//               Storage is deliberately not reset.
// Ports       : clk      - write clock
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_raddr  - read address
//               o_rdata  - read data (combinational from i_raddr)
// Revision    : 1.0 - initial release
// ============================================================================
module capture_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/trigger_capture_buf.sv
`default_nettype none
// ============================================================================
// Module      : trigger_capture_buf
// Description : Pre/post-trigger capture buffer. Once armed it records din
//               into a DEPTH-entry ring, qualifies a trigger in one of four
//               modes, freezes a DEPTH-sample window holding pre_cnt samples
//               before the trigger, and streams it out oldest first over a
//               valid/ready port.
// Ports       : clk, rst_n            - clock, async active-low reset
//               arm, abort            - start capture / return to IDLE
//               mode, pre_cnt         - trigger mode / pre-trigger samples
//               trig, din             - trigger input / sample input
//               match_val, match_mask - mode-2 compare value and mask
//               rd_data, rd_valid,
//               rd_ready, rd_last     - readout stream
//               busy, triggered, done - status
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_capture_buf
  import trigger_capture_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [AW-1:0]     pre_cnt,
  input  logic              trig,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] match_val,
  input  logic [DATA_W-1:0] match_mask,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              busy,
  output logic              triggered,
  output logic              done
);

  localparam logic [AW-1:0] c_one      = AW'(1);
  localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);

  cap_state_t        state_q, state_d;
  trig_mode_t        mode_q, mode_d;
  logic [AW-1:0]     pre_q, pre_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     trig_ptr_q, trig_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              trig_q, trig_d;
  logic              triggered_q, triggered_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              w_qual;
  logic              w_we;
  logic [AW-1:0]     w_post;
  logic [AW-1:0]     w_cnt_inc;
  logic [DATA_W-1:0] w_ram_rdata;

  // Post-trigger sample count: DEPTH-1-pre.
  assign w_post    = c_last_idx - pre_q;
  assign w_cnt_inc = cnt_q + c_one;

  // Trigger qualifier for the latched mode.
  always_comb begin
    w_qual = 1'b0;
    case (mode_q)
      MODE_LEVEL: w_qual = trig;
      MODE_EDGE:  w_qual = trig & ~trig_q;
      MODE_MATCH: w_qual = ((din & match_mask) == (match_val & match_mask));
      MODE_IMM:   w_qual = 1'b1;
      default:    w_qual = 1'b0;
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pre_d       = pre_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    trig_ptr_d  = trig_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    triggered_d = triggered_q;
    done_d      = 1'b0;
    trig_d      = trig;
    w_we        = 1'b0;

    case (state_q)
      IDLE: begin
        if (arm) begin
          mode_d      = trig_mode_t'(mode);
          pre_d       = pre_cnt;
          triggered_d = 1'b0;
          cnt_d       = '0;
          state_d     = (pre_cnt != '0) ? FILL : WAIT;
        end
      end
      FILL: begin
        w_we     = 1'b1;
        wr_ptr_d = wr_ptr_q + c_one;
        cnt_d    = w_cnt_inc;
        if (w_cnt_inc == pre_q) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        w_we     = 1'b1;
        wr_ptr_d = wr_ptr_q + c_one;
        if (w_qual) begin
          // The sample written this cycle is the trigger sample.
          trig_ptr_d  = wr_ptr_q;
          triggered_d = 1'b1;
          cnt_d       = '0;
          if (w_post != '0) begin
            state_d = POST;
          end else begin
            state_d  = READ;
            rd_ptr_d = wr_ptr_q - pre_q;
          end
        end
      end
      POST: begin
        w_we     = 1'b1;
        wr_ptr_d = wr_ptr_q + c_one;
        cnt_d    = w_cnt_inc;
        if (w_cnt_inc == w_post) begin
          state_d  = READ;
          rd_ptr_d = trig_ptr_q - pre_q;
          cnt_d    = '0;
        end
      end
      READ: begin
        // rd_valid is always high in READ, so rd_ready alone completes a beat.
        if (rd_ready) begin
          rd_ptr_d = rd_ptr_q + c_one;
          cnt_d    = w_cnt_inc;
          if (cnt_q == c_last_idx) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // abort overrides everything, including a same-cycle final handshake.
    if (abort) begin
      state_d     = IDLE;
      triggered_d = 1'b0;
      done_d      = 1'b0;
      w_we        = 1'b0;
      wr_ptr_d    = wr_ptr_q;
    end
  end

  // Outputs are registered from the next state so they align with state_q.
  // The RAM is read at the next read pointer so rd_data is ready with rd_valid.
  assign rd_valid_d = (state_d == READ);
  assign rd_last_d  = (state_d == READ) && (cnt_d == c_last_idx);
  assign busy_d     = (state_d != IDLE);
  assign rd_data_d  = (state_d == READ) ? w_ram_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= MODE_LEVEL;
      pre_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      trig_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      trig_q      <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_ptr_q  <= trig_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      trig_q      <= trig_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      busy_q      <= busy_d;
      rd_data_q   <= rd_data_d;
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (wr_ptr_q),
    .i_wdata (din),
    .i_raddr (rd_ptr_d),
    .o_rdata (w_ram_rdata)
  );

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;

endmodule
`default_nettype wire
